// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP camera capture block.
package dvp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    WAIT = 2'd2,
    RUN  = 2'd3
  } dvp_state_t;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Geometry counters stick at all-ones so a runaway line never aliases to a legal length
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/dvp_byte_packer.sv
// Pairs consecutive camera bytes (high byte first) into one 16-bit pixel
// with a single-cycle strobe; holds the last pixel between strobes.
module dvp_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        de,
  output logic [15:0] pixel,
  output logic        odd_flag
);

  logic        phase_r;
  logic [7:0]  hi_byte_r;
  logic        de_r;
  logic [15:0] pixel_r;

  // Phase toggles per byte inside a line; the odd phase completes a pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r   <= 1'b0;
      hi_byte_r <= 8'd0;
      de_r      <= 1'b0;
      pixel_r   <= 16'd0;
    end else if (!run) begin
      phase_r   <= 1'b0;
      hi_byte_r <= 8'd0;
      de_r      <= 1'b0;
      pixel_r   <= 16'd0;
    end else if (href) begin
      phase_r <= ~phase_r;
      if (phase_r) begin
        de_r    <= 1'b1;
        pixel_r <= {hi_byte_r, data};
      end else begin
        de_r      <= 1'b0;
        hi_byte_r <= data;
      end
    end else begin
      phase_r <= 1'b0;
      de_r    <= 1'b0;
    end
  end

  assign de       = de_r;
  assign pixel    = pixel_r;
  assign odd_flag = phase_r;

endmodule

// File: rtl/dvp_capture.sv
// DVP camera front end: discards settling frames after enable, forwards
// RGB565 pixels and flags line/frame geometry errors.
module dvp_capture
  import dvp_pkg::*;
#(
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr_err,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        vi_clk,
  output logic        vi_vs,
  output logic        vi_de,
  output logic [15:0] vi_data,
  output logic        armed,
  output logic [15:0] frame_cnt,
  output logic        err_h,
  output logic        err_v,
  output logic        err_odd
);

  localparam logic [CNT_W-1:0] H_EXP  = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_EXP  = CNT_W'(V_DISP);
  localparam logic [15:0]      SKIP_N = 16'(SKIP_FRAMES);

  dvp_state_t       state_r;
  logic             vsync_d1_r, vsync_d2_r, href_d1_r, href_d2_r;
  logic [7:0]       data_d1_r;
  logic [15:0]      skip_cnt_r, skip_next_s, frame_cnt_r;
  logic [CNT_W-1:0] pix_cnt_r, line_cnt_r, line_next_s;
  logic             armed_r, err_h_r, err_v_r, err_odd_r;
  logic             vs_rise_s, vs_fall_s, href_fall_s, run_s, pix_inc_s;
  logic             h_bad_s, v_bad_s, odd_bad_s;
  logic             pk_de_s, pk_odd_s;
  logic [15:0]      pk_pixel_s;

  // Input register stage plus a second VSYNC/HREF tap for edge detection
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      vsync_d1_r <= 1'b0;
      vsync_d2_r <= 1'b0;
      href_d1_r  <= 1'b0;
      href_d2_r  <= 1'b0;
      data_d1_r  <= 8'd0;
    end else begin
      vsync_d1_r <= cam_vsync;
      vsync_d2_r <= vsync_d1_r;
      href_d1_r  <= cam_href;
      href_d2_r  <= href_d1_r;
      data_d1_r  <= cam_data;
    end
  end

  assign vs_rise_s   = vsync_d1_r & ~vsync_d2_r;
  assign vs_fall_s   = ~vsync_d1_r & vsync_d2_r;
  assign href_fall_s = ~href_d1_r & href_d2_r;
  assign run_s       = (state_r == RUN);
  // Counted on the same condition the packer emits on, so the count is complete at the HREF fall
  assign pix_inc_s   = run_s & href_d1_r & pk_odd_s;
  assign skip_next_s = skip_cnt_r + 16'd1;

  // Line count including a line that ends in the same cycle as the frame
  always_comb begin
    line_next_s = line_cnt_r;
    if (href_fall_s) begin
      line_next_s = sat_inc(line_cnt_r);
    end else begin
      line_next_s = line_cnt_r;
    end
  end

  assign h_bad_s   = run_s & href_fall_s & (pix_cnt_r != H_EXP);
  assign odd_bad_s = run_s & href_fall_s & pk_odd_s;
  assign v_bad_s   = run_s & vs_rise_s & (line_next_s != V_EXP);

  // Frame sequencing: settle, align to a frame start, then forward whole frames
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      skip_cnt_r  <= 16'd0;
      frame_cnt_r <= 16'd0;
      armed_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en) begin
            state_r    <= SKIP;
            skip_cnt_r <= 16'd0;
          end
        end
        SKIP: begin
          if (!en) begin
            state_r <= IDLE;
          end else if (vs_rise_s) begin
            skip_cnt_r <= skip_next_s;
            if (skip_next_s >= SKIP_N) begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!en) begin
            state_r <= IDLE;
          end else if (vs_fall_s) begin
            state_r <= RUN;
            armed_r <= 1'b1;
          end
        end
        RUN: begin
          if (vs_rise_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            if (!en) begin
              state_r <= IDLE;
              armed_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          armed_r <= 1'b0;
        end
      endcase
    end
  end

  // Geometry counters, restarted at every frame start
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      pix_cnt_r  <= {CNT_W{1'b0}};
      line_cnt_r <= {CNT_W{1'b0}};
    end else if (vs_fall_s) begin
      pix_cnt_r  <= {CNT_W{1'b0}};
      line_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (href_fall_s) begin
        pix_cnt_r <= {CNT_W{1'b0}};
      end else if (pix_inc_s) begin
        pix_cnt_r <= sat_inc(pix_cnt_r);
      end
      line_cnt_r <= line_next_s;
    end
  end

  // Sticky error flags; a new error outranks a clear in the same cycle
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      err_h_r   <= 1'b0;
      err_v_r   <= 1'b0;
      err_odd_r <= 1'b0;
    end else begin
      err_h_r   <= h_bad_s   | (err_h_r   & ~clr_err);
      err_v_r   <= v_bad_s   | (err_v_r   & ~clr_err);
      err_odd_r <= odd_bad_s | (err_odd_r & ~clr_err);
    end
  end

  dvp_byte_packer u_packer (
    .clk      (cam_pclk),
    .rst_n    (rst_n),
    .run      (run_s),
    .href     (href_d1_r),
    .data     (data_d1_r),
    .de       (pk_de_s),
    .pixel    (pk_pixel_s),
    .odd_flag (pk_odd_s)
  );

  assign vi_clk    = cam_pclk;
  assign vi_vs     = vsync_d2_r & armed_r;
  assign vi_de     = pk_de_s;
  assign vi_data   = run_s ? pk_pixel_s : 16'd0;
  assign armed     = armed_r;
  assign frame_cnt = frame_cnt_r;
  assign err_h     = err_h_r;
  assign err_v     = err_v_r;
  assign err_odd   = err_odd_r;

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench for dvp_capture with a small 4x2 frame geometry.
module tb_dvp_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 2;

  logic        cam_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        vi_clk, vi_vs, vi_de, armed, err_h, err_v, err_odd;
  logic [15:0] vi_data, frame_cnt;

  dvp_capture #(.H_DISP(H), .V_DISP(V), .SKIP_FRAMES(SK)) dut (
    .cam_pclk  (cam_pclk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_err   (clr_err),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .vi_clk    (vi_clk),
    .vi_vs     (vi_vs),
    .vi_de     (vi_de),
    .vi_data   (vi_data),
    .armed     (armed),
    .frame_cnt (frame_cnt),
    .err_h     (err_h),
    .err_v     (err_v),
    .err_odd   (err_odd)
  );

  always #5 cam_pclk = ~cam_pclk;

  int cyc = 0;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          due_q[$];
  logic [15:0] mon_exp;
  int          mon_due;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected pixel and its due cycle
  always @(negedge cam_pclk) begin
    if (vi_de === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got vi_de=1 data=%h, required no strobe (t=%0t)", vi_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_due = due_q.pop_front();
        check("pixel_data", {16'd0, vi_data}, {16'd0, mon_exp});
        check("pixel_latency", cyc, mon_due);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One line of nb bytes taken MSB-first from pat; optional clr_err pulse timed onto the HREF-fall detection
  task automatic send_line(input int nb, input logic [63:0] pat, input bit fwd, input bit clr_at_fall);
    logic [7:0] hi, b;
    hi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = pat[63-8*i -: 8];
      @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = b;
      if (i % 2 == 0) begin
        hi = b;
      end else if (fwd) begin
        exp_q.push_back({hi, b});
        due_q.push_back(cyc + 2);
      end
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    @(negedge cam_pclk);
    clr_err = clr_at_fall;
    @(negedge cam_pclk);
    clr_err = 1'b0;
    repeat (2) @(negedge cam_pclk);
  endtask

  task automatic vs_pulse(input logic exp_vs);
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    @(negedge cam_pclk);
    check("vi_vs_early", {31'd0, vi_vs}, 32'd0);
    @(negedge cam_pclk);
    check("vi_vs", {31'd0, vi_vs}, {31'd0, exp_vs});
    repeat (2) @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge cam_pclk);
  endtask

  task automatic send_frame(input int nlines, input logic [11:0] lens, input bit fwd, input int clr_line,
                            input bit drop_en, input logic [63:0] pat, input logic exp_vs);
    repeat (3) @(negedge cam_pclk);
    for (int l = 0; l < nlines; l++) begin
      send_line(int'(lens[4*l +: 4]), pat, fwd, l == clr_line);
      if (drop_en && l == 0) en = 1'b0;
    end
    vs_pulse(exp_vs);
  endtask

  task automatic pulse_clr();
    @(negedge cam_pclk);
    clr_err = 1'b1;
    @(negedge cam_pclk);
    clr_err = 1'b0;
    @(negedge cam_pclk);
  endtask

  task automatic check_state(input string tag, input logic exp_armed, input logic [15:0] exp_fc, input logic [2:0] exp_err);
    check({tag, "_armed"}, {31'd0, armed}, {31'd0, exp_armed});
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, exp_fc});
    check({tag, "_errs"}, {29'd0, err_h, err_v, err_odd}, {29'd0, exp_err});
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge cam_pclk);
    check("rst_outputs", {28'd0, vi_de, vi_vs, armed, err_h | err_v | err_odd}, 32'd0);
    check("rst_data", {vi_data, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge cam_pclk);
    en = 1'b1;

    // Two settling frames, then two forwarded ones (second carries 0xF8,0x1F first)
    send_frame(2, 12'h088, 1'b0, -1, 1'b0, 64'h1122_3344_5566_7788, 1'b0);
    check_state("skip1", 1'b0, 16'd0, 3'b000);
    send_frame(2, 12'h088, 1'b0, -1, 1'b0, 64'h99AA_BBCC_DDEE_FF00, 1'b0);
    check_state("wait", 1'b1, 16'd0, 3'b000);
    send_frame(2, 12'h088, 1'b1, -1, 1'b0, 64'h0102_0304_0506_0708, 1'b1);
    check_state("frame1", 1'b1, 16'd1, 3'b000);
    send_frame(2, 12'h088, 1'b1, -1, 1'b0, 64'hF81F_07E0_001F_FFFF, 1'b1);
    check_state("frame2", 1'b1, 16'd2, 3'b000);

    // Short line sets err_h, which stays set until cleared
    send_frame(2, 12'h068, 1'b1, -1, 1'b0, 64'hA0A1_A2A3_A4A5_A6A7, 1'b1);
    check_state("short_line", 1'b1, 16'd3, 3'b100);
    send_frame(2, 12'h088, 1'b1, -1, 1'b0, 64'hB0B1_B2B3_B4B5_B6B7, 1'b1);
    check_state("err_h_sticky", 1'b1, 16'd4, 3'b100);
    pulse_clr();
    check("err_h_cleared", {29'd0, err_h, err_v, err_odd}, 32'd0);

    // Seven-byte line: three pixels, last byte dropped
    send_frame(2, 12'h078, 1'b1, -1, 1'b0, 64'hC0C1_C2C3_C4C5_C6C7, 1'b1);
    check_state("odd_line", 1'b1, 16'd5, 3'b101);
    pulse_clr();

    // Three-line frame, then clr_err colliding with a fresh err_h
    send_frame(3, 12'h888, 1'b1, -1, 1'b0, 64'hD0D1_D2D3_D4D5_D6D7, 1'b1);
    check_state("tall_frame", 1'b1, 16'd6, 3'b010);
    pulse_clr();
    check("err_v_cleared", {29'd0, err_h, err_v, err_odd}, 32'd0);
    send_frame(2, 12'h086, 1'b1, 0, 1'b0, 64'hE0E1_E2E3_E4E5_E6E7, 1'b1);
    check_state("set_beats_clr", 1'b1, 16'd7, 3'b100);
    pulse_clr();

    // Disable mid-frame: frame completes, then IDLE; re-enable skips two again
    send_frame(2, 12'h088, 1'b1, -1, 1'b1, 64'h1357_9BDF_2468_ACE0, 1'b0);
    check_state("disabled", 1'b0, 16'd8, 3'b000);
    @(negedge cam_pclk);
    en = 1'b1;
    send_frame(2, 12'h088, 1'b0, -1, 1'b0, 64'h5A5A_A5A5_5A5A_A5A5, 1'b0);
    send_frame(2, 12'h088, 1'b0, -1, 1'b0, 64'h3C3C_C3C3_3C3C_C3C3, 1'b0);
    check_state("reskip", 1'b1, 16'd8, 3'b000);
    send_frame(3, 12'h888, 1'b1, -1, 1'b0, 64'h0F0F_F0F0_0F0F_F0F0, 1'b1);
    check_state("rearmed", 1'b1, 16'd9, 3'b010);

    // Reset in the middle of a forwarded line
    repeat (3) @(negedge cam_pclk);
    cam_href = 1'b1;
    cam_data = 8'h12;
    @(negedge cam_pclk);
    cam_data = 8'h34;
    exp_q.push_back(16'h1234);
    due_q.push_back(cyc + 2);
    @(negedge cam_pclk);
    cam_data = 8'h56;
    @(negedge cam_pclk);
    rst_n = 1'b0;
    cam_data = 8'h78;
    @(negedge cam_pclk);
    check("midline_rst_flags", {26'd0, vi_de, vi_vs, armed, err_h, err_v, err_odd}, 32'd0);
    check("midline_rst_data", {vi_data, frame_cnt}, 32'd0);
    repeat (2) @(negedge cam_pclk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    rst_n = 1'b1;

    send_frame(2, 12'h088, 1'b0, -1, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
    send_frame(2, 12'h088, 1'b0, -1, 1'b0, 64'h5555_6666_7777_8888, 1'b0);
    check_state("post_rst_skip", 1'b1, 16'd0, 3'b000);
    send_frame(2, 12'h088, 1'b1, -1, 1'b0, 64'h8421_4218_2184_1842, 1'b1);
    check_state("post_rst_run", 1'b1, 16'd1, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvp_capture.md
# dvp_capture

Camera front end for the video-processing chain. Samples an 8-bit DVP camera bus (OV5640-style: PCLK, VSYNC, HREF, D[7:0]), discards the first frames after enable while the sensor settles, and packs byte pairs into RGB565 pixels. Produces the vs/de/16-bit video stream consumed by the video-processing pipeline's `vi_*` inputs. Also checks frame geometry and reports errors through sticky flags.

## Interface
- `H_DISP`, default 1280: expected pixels per line.
- `V_DISP`, default 720: expected lines per frame.
- `SKIP_FRAMES`, default 10: frames discarded after enable or reset; must be ≥ 1.
- `cam_pclk` in 1: camera pixel clock; the only clock in this block.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: capture enable.
- `clr_err` in 1: one-cycle pulse that clears the error flags.
- `cam_vsync` in 1: frame sync, active high during vertical blanking.
- `cam_href` in 1: line valid, active high.
- `cam_data` in 8: camera byte; high byte of each pixel first.
- `vi_clk` out 1: equals `cam_pclk` (direct assign).
- `vi_vs` out 1: frame sync to downstream.
- `vi_de` out 1: one-cycle pixel-valid strobe.
- `vi_data` out 16: RGB565 pixel, `{R[4:0], G[5:0], B[4:0]}`.
- `armed` out 1: high while frames are being forwarded.
- `frame_cnt` out 16: count of forwarded frames; wraps.
- `err_h` out 1: sticky; a line length was not equal to `H_DISP`.
- `err_v` out 1: sticky; a frame height was not equal to `V_DISP`.
- `err_odd` out 1: sticky; a line ended with an unpaired byte.

## Operation
- **Input registers:** all camera inputs pass through one input register stage (`*_d1`). VSYNC edges are detected from `vsync_d1` and `vsync_d2`.
- **State machine states:** IDLE, SKIP, WAIT, RUN.
  - IDLE: leave when `en`=1; go to SKIP with `skip_cnt`=0.
  - SKIP: increment `skip_cnt` on each VSYNC rising edge. Go to WAIT when `skip_cnt` reaches `SKIP_FRAMES`. If `en`=0, go to IDLE.
  - WAIT: go to RUN on the next VSYNC falling edge (start of a frame). Entering RUN sets `armed`=1.
  - RUN: on each VSYNC rising edge (end of frame), increment `frame_cnt` and run the height check. If `en`=0 at that edge, go to IDLE and clear `armed`. `en` dropping mid-frame never truncates a frame.
- **Byte packer (active only in RUN):**
  - When `href_d1`=1, `phase` toggles each cycle.
  - phase 0: latch `hi_byte`.
  - phase 1: emit `{hi_byte, data_d1}` with `vi_de`=1.
  - `phase` clears when `href_d1`=0.
- **Line and frame counters:**
  - `pix_cnt` (11 bits) counts emitted pixels; `line_cnt` (11 bits) counts HREF falling edges. Both clear on VSYNC falling edge.
  - At an HREF falling edge: if `pix_cnt` ≠ `H_DISP`, set `err_h`; if `phase`=1, set `err_odd` and drop the half pixel. `pix_cnt` then clears.
  - At a VSYNC rising edge in RUN: if `line_cnt` ≠ `V_DISP`, set `err_v`.
- **Counter widths and saturation:** `pix_cnt` and `line_cnt` saturate at 2047 and do not wrap. `frame_cnt` wraps from 0xFFFF to 0.
- **Outputs:** `vi_vs` = `vsync_d2 & armed`. `vi_de` and `vi_data` are 0 outside RUN.
- **Error flags:** sticky until `clr_err` or reset. If `clr_err` and a new error occur in the same cycle, the set wins.

## Timing
- **Reset values:** state IDLE; all outputs 0 except `vi_clk`; all counters 0.
- **Reset mid-operation:** identical to power-up. The skip sequence restarts.
- **Pixel latency:** the second byte sampled at pins on edge k produces `vi_de`=1 with valid `vi_data` at edge k+2, for exactly one cycle.
- **Pixel rate:** at most one pixel every 2 cycles. `vi_data` holds its value between strobes.
- **VSYNC latency:** `vi_vs` follows `cam_vsync` with 2-cycle latency, matching the data path. `vi_vs` rises for the first time at the end of the first forwarded frame.
- **Simultaneous HREF fall and VSYNC rise:** the line is processed first, then the frame check. The height check therefore includes that line.

## Structure
- **Package `dvp_pkg`:** state enum `dvp_state_t` {IDLE, SKIP, WAIT, RUN}; counter width localparam `CNT_W` = 11.
- **Sub-module `dvp_byte_packer`:** contains the phase toggle, the hi-byte latch and the output register. Ports: clk, rst_n, run, href, data → de, pixel, odd_flag.
- **Top level:** the FSM, edge detection, counters and error flags.

## Test plan
Bench parameters: `H_DISP`=4, `V_DISP`=2, `SKIP_FRAMES`=2. A frame is 2 lines of 8 bytes each.

1. Reset, then `en`=1, then feed 4 clean frames. Expect no `vi_de` during frames 1–2 and the WAIT period. Expect 8 `vi_de` strobes per forwarded frame, `frame_cnt`=1 after the first forwarded VSYNC rise, and all errors 0.
2. Byte pair 0xF8, 0x1F sent in RUN. Expect `vi_data`=0xF81F, strobed exactly 2 cycles after 0x1F is on the pins.
3. A line of 6 bytes. Expect `err_h`=1 at that HREF fall; it stays 1 until a `clr_err` pulse, then reads 0.
4. A line of 7 bytes. Expect `err_odd`=1, 3 pixels emitted, and the last byte dropped.
5. A frame with 3 lines. Expect `err_v`=1 at the VSYNC rise. Then assert `clr_err` in the same cycle a new `err_h` occurs: `err_h` must remain 1.
6. Drop `en` mid-frame in RUN. Expect the current frame to complete with 8 strobes, then IDLE and `armed`=0. Re-enable `en`: expect 2 frames skipped again. Assert `rst_n`=0 mid-line: expect all outputs 0 at the next edge.
